// File: rtl/ex_div_if.sv
// Divider request/response bundle between EX and ex_div.
// EX drives operands, start_i and annul_i; the divider returns result_o, ready_o and busy_o.
interface ex_div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i,
    output start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i,
    input  start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/ex_div.sv
// EX-stage iterative radix-2 restoring divider for DIV/DIVU.
// Ports: clk, rst (sync active-low), bus (ex_div_if.slave):
//   signed_div_i, opdata1_i, opdata2_i, start_i, annul_i in;
//   result_o = {remainder, quotient}, ready_o, busy_o out.
// Optional: define DIV_OVERFLOW_EN to shortcut DIV 0x80000000 / -1.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  ex_div_if.slave    bus
);

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     dsr_q, dsr_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
`ifdef DIV_OVERFLOW_EN
  logic                  ovf_q, ovf_d;
  logic                  is_ovf;
`endif

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     abs1, abs2;
  logic [DATA_W:0]       shifted;
  logic [DATA_W+1:0]     sub;
  logic                  borrow;
  logic [DATA_W-1:0]     rem_nx, quo_nx;
  logic                  last;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign abs1    = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2    = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_OVERFLOW_EN
  assign is_ovf = bus.signed_div_i
    && (bus.opdata1_i == {1'b1, {(DATA_W-1){1'b0}}})
    && (&bus.opdata2_i);
`endif

  // Partial remainder picks up the next dividend bit from the top of
  // quo_q; quotient bits fill quo_q from the bottom as it drains.
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign sub     = {1'b0, shifted} - {2'b00, dsr_q};
  assign borrow  = sub[DATA_W+1];
  assign rem_nx  = borrow ? shifted[DATA_W-1:0] : sub[DATA_W-1:0];
  assign quo_nx  = {quo_q[DATA_W-2:0], ~borrow};
  assign last    = (cnt_q == CNT_W'(DATA_W-1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = BYZERO;
`ifdef DIV_OVERFLOW_EN
            ovf_d   = 1'b0;
          end else if (is_ovf) begin
            state_d = BYZERO;
            ovf_d   = 1'b1;
`endif
          end else begin
            state_d = ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs1;
            dsr_d   = abs2;
            negq_d  = op1_neg ^ op2_neg;
            negr_d  = op1_neg;
          end
        end
      end
      BYZERO: begin
        state_d  = END;
        ready_d  = 1'b1;
        result_d = '0;
`ifdef DIV_OVERFLOW_EN
        if (ovf_q)
          result_d = {{DATA_W{1'b0}},
                      1'b1, {(DATA_W-1){1'b0}}};
`endif
      end
      ON: begin
        if (bus.annul_i) begin
          state_d = FREE;
          ready_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (last) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {negr_q ? -rem_nx : rem_nx,
                        negq_q ? -quo_nx : quo_nx};
          end
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_d = FREE;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
`ifdef DIV_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = (state_q != FREE);

endmodule

// File: tb/tb_ex_div.sv
// Testbench for ex_div: directed divisions, scoreboard of results
// and start-to-ready latency, plus annul/reset/hold checks.
module tb_ex_div;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  ex_div_if #(.DATA_W(32)) bus ();

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          sc_q[$];
  logic        prev_rdy;

`ifdef DIV_OVERFLOW_EN
  localparam int OVF_LAT = 2;
`else
  localparam int OVF_LAT = 33;
`endif

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o consumes one expectation.
  initial prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (bus.ready_o && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h expected none",
                 bus.result_o);
      end else begin
        logic [63:0] e;
        int          l;
        int          s;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        s = sc_q.pop_front();
        chk("result", bus.result_o, e);
        chk("latency", 64'(cyc - s), 64'(l));
      end
    end
    prev_rdy = bus.ready_o;
  end

  // Caller positions time away from the rising edge before calling.
  task automatic do_div(input logic        s,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp,
                        input int          lat,
                        input int          hold);
    int   n;
    logic bad_busy;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    sc_q.push_back(cyc);
    @(posedge clk);
    #1;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    n        = 0;
    bad_busy = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.ready_o && !bus.busy_o) bad_busy = 1'b1;
    end while (!bus.ready_o && n < 100);
    chk("ready_seen", 64'(bus.ready_o), 64'd1);
    chk("busy_while_running", 64'(bad_busy), 64'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", 64'(bus.ready_o), 64'd1);
      chk("hold_result", bus.result_o, exp);
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("free_ready", 64'(bus.ready_o), 64'd0);
    chk("free_busy", 64'(bus.busy_o), 64'd0);
    chk("retained", bus.result_o, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b1;

    @(posedge clk); #1;
    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'hE}, 33, 0);
    @(posedge clk); #1;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE,
           {32'd1, 32'hFFFF_FFFD}, 33, 0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
           {32'hFFFF_FFFE, 32'd14}, 33, 0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 64'd0, 2, 5);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10,
           {32'hF, 32'h0FFF_FFFF}, 33, 0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           {32'h8000_0000, 32'd0}, 33, 0);
    do_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33, 0);

    // start together with annul must not launch a division
    bus.opdata1_i = 32'd8;
    bus.opdata2_i = 32'd2;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("start_annul_busy", 64'(bus.busy_o), 64'd0);
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // annul mid-division, then an immediate new request
    @(posedge clk); #1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFF_FFFF;
    bus.opdata2_i    = 32'd1;
    bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    @(negedge clk);
    chk("annul_busy", 64'(bus.busy_o), 64'd0);
    chk("annul_ready", 64'(bus.ready_o), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    // reset mid-division, then start in the first cycle after it
    @(posedge clk); #1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_result", bus.result_o, 64'd0);
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b1;
    do_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 0);

    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           {32'd0, 32'h8000_0000}, OVF_LAT, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative 32-bit radix-2 restoring divider for the EX stage; serves DIV/DIVU.
- Operands come straight from the ID/EX register outputs (reg1 = dividend, reg2 = divisor).
- EX holds the pipeline stalled while the divider is busy, then writes result_o to HI/LO (HI = remainder, LO = quotient).
- One division in flight at a time.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W.
- CNT_W, 6, width of the iteration counter; must hold the value DATA_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk; rst==0 resets.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend; sampled only in the start cycle.
- opdata2_i  in  DATA_W  divisor; sampled only in the start cycle.
- start_i  in  1  request; level-held by EX until ready_o is seen.
- annul_i  in  1  abort (branch flush/exception); overrides start_i.
- result_o  out  2*DATA_W  {remainder, quotient}.
- ready_o  out  1  result_o valid.
- busy_o  out  1  high in any state other than FREE; used by EX for stallreq.

Behaviour:
- Reset (rst==0 at an edge, any state, including mid-division): state=FREE, cnt=0, result_o=0, ready_o=0, busy_o=0. Partial work is discarded.
- States are FREE, BYZERO, ON, END.
- FREE, start_i=1, annul_i=0:
  - opdata2_i==0 -> BYZERO.
  - Otherwise -> ON. Latch the operands; if signed_div_i, replace a negative operand with its two's complement magnitude. Latch the sign flags. Dividend register = {0, |op1|}, cnt=0.
- FREE, start_i=0 or annul_i=1: remain in FREE.
- BYZERO: next edge -> END with result_o=0.
- ON, one iteration per cycle:
  - Shift the partial remainder left by 1, bringing in the next dividend bit (MSB first).
  - Trial subtract the divisor. If the difference is >=0 (no borrow), keep the difference and set quotient bit 1; else restore and set bit 0.
  - cnt++.
  - At the edge completing iteration DATA_W-1: apply sign fixups and go to END, registering result_o and ready_o=1 on the same edge.
  - Sign fixups (signed only): quotient negated if sign(op1)!=sign(op2); remainder negated if op1<0 (remainder takes the dividend's sign).
- ON, annul_i=1: next edge -> FREE, ready_o=0, result_o unchanged.
- END: ready_o=1 and result_o held stable. start_i=0 -> FREE on the next edge, with ready_o=0 and result_o retained. start_i=1 -> stay in END.
- Latency (start sampled in cycle N):
  - Normal division: ready_o is high from cycle N+33.
  - Divide by zero: ready_o is high from cycle N+2.
- Operand changes after the start cycle have no effect.
- start_i together with annul_i in FREE: no start.
- Unsigned arithmetic uses a DATA_W+1-bit subtractor; the borrow bit decides each quotient bit.

Optional Feature:
- Macro: DIV_OVERFLOW_EN.
- Defined: signed_div_i=1, op1=0x80000000, op2=0xFFFFFFFF takes a fast path. FREE -> BYZERO-like single-cycle path -> END with result_o={0x00000000, 0x80000000}; ready_o high in cycle N+2.
- Undefined: the same operands take the full iterative path and produce the identical result in cycle N+33.
- All other operand pairs are unaffected either way.

Test Plan:
- DIVU 100/7, start held -> ready_o rises exactly 33 cycles after start; result_o={0x00000002, 0x0000000E}; busy_o high throughout.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. Then DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- DIVU 0x12345678/0 -> ready_o in cycle N+2, result_o=0. Hold start_i for 5 cycles -> ready_o stays 1 and result stable. Drop start_i -> FREE next cycle, ready_o=0.
- Start DIVU 0xFFFFFFFF/1, pulse annul_i at iteration 10 -> FREE next cycle, ready_o never asserts. Immediate new DIVU 9/3 -> {0, 3} at N+33.
- Drive rst=0 for one edge at iteration 20 -> all outputs 0, state FREE. A start in the first cycle after reset is accepted normally.
- DIV 0x80000000/0xFFFFFFFF -> result_o={0, 0x80000000}. Ready at N+2 with DIV_OVERFLOW_EN defined, N+33 without.
